// File: rtl/rv_mem_pkg.sv
// Shared types and I/O register offsets for the RISC-V memory responder.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Byte offsets inside the 256-byte I/O window
    localparam logic [7:0] IO_HALT   = 8'h00;
    localparam logic [7:0] IO_CYCLE  = 8'h04;
    localparam logic [7:0] IO_STATUS = 8'h08;

endpackage

// File: rtl/rv_mem_array.sv
// Unified word array: two registered read ports and one write port.
// Reads return the pre-write contents when they hit the word being written.
module rv_mem_array #(
    parameter int DW    = 32,
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [WORDS];

    // Contents deliberately have no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/rv_mem_resp.sv
// Memory responder for the multicycle RISC-V core: program load port,
// instruction/data ports over one word array, and a small I/O register window.
module rv_mem_resp
    import rv_mem_pkg::*;
#(
    parameter int                 DPWIDTH  = 32,
    parameter int                 MEMWORDS = 1024,
    parameter logic [DPWIDTH-1:0] IO_BASE  = 32'hFFFF_FF00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] imem_addr,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_dataout,
    input  logic               memrw,
    output logic [DPWIDTH-1:0] imem_datain,
    output logic [DPWIDTH-1:0] dmem_datain,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [DPWIDTH-1:0] ld_addr,
    input  logic [DPWIDTH-1:0] ld_data,
    input  logic               ld_done,
    output logic               core_run,
    output logic               halted,
    output logic [DPWIDTH-1:0] halt_code
);

    localparam int AW = $clog2(MEMWORDS);

    state_t             state_reg, state_next;
    logic [DPWIDTH-1:0] cycle_reg;
    logic [DPWIDTH-1:0] halt_code_reg;
    logic               misalign_reg;
    logic               isel_reg;
    logic               dsel_mem_reg;
    logic [DPWIDTH-1:0] io_rdata_reg, io_rdata_next;

    logic               i_in_io, d_in_io;
    logic [7:0]         d_off;
    logic               core_store, io_store, halt_store;

    logic               ram_we;
    logic [AW-1:0]      ram_waddr;
    logic [DPWIDTH-1:0] ram_wdata;
    logic [DPWIDTH-1:0] ram_rdata_a, ram_rdata_b;

    // Address bits outside the word index are aliased away on purpose
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr, ld_addr};

    assign i_in_io    = (imem_addr[DPWIDTH-1:8] == IO_BASE[DPWIDTH-1:8]);
    assign d_in_io    = (dmem_addr[DPWIDTH-1:8] == IO_BASE[DPWIDTH-1:8]);
    assign d_off      = dmem_addr[7:0];
    assign core_store = (state_reg == ST_RUN) && memrw;
    assign io_store   = core_store && d_in_io;
    assign halt_store = io_store && (d_off == IO_HALT);

    // Write port: the bench owns it while loading, the core owns it while running
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = dmem_addr[AW+1:2];
        ram_wdata = dmem_dataout;
        if (state_reg == ST_LOAD) begin
            ram_we    = ld_valid;
            ram_waddr = ld_addr[AW+1:2];
            ram_wdata = ld_data;
        end else if (core_store && !d_in_io) begin
            ram_we = 1'b1;
        end
    end

    rv_mem_array #(
        .DW    (DPWIDTH),
        .WORDS (MEMWORDS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (imem_addr[AW+1:2]),
        .rdata_a (ram_rdata_a),
        .raddr_b (dmem_addr[AW+1:2]),
        .rdata_b (ram_rdata_b)
    );

    // I/O reads use the register values from before this edge's updates
    always_comb begin
        io_rdata_next = '0;
        if (d_in_io) begin
            case (d_off)
                IO_HALT:   io_rdata_next = halt_code_reg;
                IO_CYCLE:  io_rdata_next = cycle_reg;
                IO_STATUS: io_rdata_next = {{(DPWIDTH-1){1'b0}}, misalign_reg};
                default:   io_rdata_next = '0;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD: if (ld_done)    state_next = ST_RUN;
            ST_RUN:  if (halt_store) state_next = ST_HALT;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_LOAD;
            cycle_reg     <= '0;
            halt_code_reg <= '0;
            misalign_reg  <= 1'b0;
            isel_reg      <= 1'b0;
            dsel_mem_reg  <= 1'b0;
            io_rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_RUN) begin
                cycle_reg <= cycle_reg + DPWIDTH'(1);
            end
            if (halt_store) begin
                halt_code_reg <= dmem_dataout;
            end
            // Sticky flag: a misaligned store wins over a clear in the same cycle
            if (core_store && (dmem_addr[1:0] != 2'b00)) begin
                misalign_reg <= 1'b1;
            end else if (io_store && (d_off == IO_STATUS) && dmem_dataout[0]) begin
                misalign_reg <= 1'b0;
            end
            isel_reg     <= !i_in_io;
            dsel_mem_reg <= !d_in_io;
            io_rdata_reg <= io_rdata_next;
        end
    end

    // io_rdata_reg is zero whenever the array is selected or after reset
    assign imem_datain = isel_reg ? ram_rdata_a : '0;
    assign dmem_datain = dsel_mem_reg ? ram_rdata_b : io_rdata_reg;
    assign ld_ready    = (state_reg == ST_LOAD);
    assign core_run    = (state_reg == ST_RUN);
    assign halted      = (state_reg == ST_HALT);
    assign halt_code   = halt_code_reg;

endmodule

// File: tb/tb_rv_mem_resp.sv
// Directed bench for rv_mem_resp: a behavioural model checked every cycle,
// plus hand-computed expectations along the program/run/halt/reset sequence.
module tb_rv_mem_resp;

    localparam logic [31:0] IOB = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, dmem_addr, dmem_dataout, ld_addr, ld_data;
    logic        memrw, ld_valid, ld_done;
    logic [31:0] imem_datain, dmem_datain, halt_code;
    logic        ld_ready, core_run, halted;

    int total = 0;
    int bad   = 0;

    rv_mem_resp #(.DPWIDTH(32), .MEMWORDS(1024), .IO_BASE(IOB)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .dmem_addr    (dmem_addr),
        .dmem_dataout (dmem_dataout),
        .memrw        (memrw),
        .imem_datain  (imem_datain),
        .dmem_datain  (dmem_datain),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_done      (ld_done),
        .core_run     (core_run),
        .halted       (halted),
        .halt_code    (halt_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Behavioural model: mode 0=loading, 1=running, 2=halted
    logic [31:0] mm [1024];
    bit          kn [1024];
    int          mode;
    logic [31:0] m_cyc, m_hcode, e_imem, e_dmem;
    bit          m_stat, e_imem_k, e_dmem_k;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode = 0; m_cyc = 0; m_hcode = 0; m_stat = 0;
            e_imem = 0; e_imem_k = 1; e_dmem = 0; e_dmem_k = 1;
        end else begin
            if (imem_addr >= IOB) begin
                e_imem = 0; e_imem_k = 1;
            end else begin
                e_imem = mm[widx(imem_addr)]; e_imem_k = kn[widx(imem_addr)];
            end
            e_dmem_k = 1;
            if (dmem_addr >= IOB) begin
                if (dmem_addr - IOB == 0)      e_dmem = m_hcode;
                else if (dmem_addr - IOB == 4) e_dmem = m_cyc;
                else if (dmem_addr - IOB == 8) e_dmem = {31'b0, m_stat};
                else                           e_dmem = 0;
            end else begin
                e_dmem = mm[widx(dmem_addr)]; e_dmem_k = kn[widx(dmem_addr)];
            end
            if (mode == 0) begin
                if (ld_valid) begin
                    mm[widx(ld_addr)] = ld_data; kn[widx(ld_addr)] = 1;
                end
                if (ld_done) mode = 1;
            end else if (mode == 1) begin
                m_cyc = m_cyc + 1;
                if (memrw) begin
                    if (dmem_addr % 4 != 0) m_stat = 1;
                    if (dmem_addr >= IOB) begin
                        if (dmem_addr == IOB) begin
                            m_hcode = dmem_dataout; mode = 2;
                        end else if (dmem_addr == IOB + 8 && dmem_dataout[0]) begin
                            m_stat = 0;
                        end
                    end else begin
                        mm[widx(dmem_addr)] = dmem_dataout; kn[widx(dmem_addr)] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, mode == 0});
        chk("core_run", {31'b0, core_run}, {31'b0, mode == 1});
        chk("halted", {31'b0, halted}, {31'b0, mode == 2});
        chk("halt_code", halt_code, m_hcode);
        if (e_imem_k) chk("imem", imem_datain, e_imem);
        if (e_dmem_k) chk("dmem", dmem_datain, e_dmem);
    end

    // One clock: inputs already set after a falling edge, results visible at the next
    task automatic tick(input string what);
        @(negedge clk);
        $display("t=%0t %s ia=%h da=%h wr=%b wd=%h -> i=%h d=%h run=%b halt=%b",
                 $time, what, imem_addr, dmem_addr, memrw, dmem_dataout,
                 imem_datain, dmem_datain, core_run, halted);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memrw = 1; dmem_addr = a; dmem_dataout = d;
        tick("store");
        memrw = 0;
    endtask

    task automatic load(input logic [31:0] a);
        dmem_addr = a;
        tick("load");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) kn[i] = 0;
        rst = 1; imem_addr = 0; dmem_addr = 0; dmem_dataout = 0; memrw = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0; ld_done = 0;
        #1 rst = 0;
        repeat (2) @(negedge clk);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("rst_core_run", {31'b0, core_run}, 32'd0);
        chk("rst_dmem", dmem_datain, 32'd0);
        #2 rst = 1;

        // Program load; the last word arrives together with ld_done
        ld_valid = 1; ld_addr = 32'h0; ld_data = 32'h0000_0013;
        tick("ld");
        ld_addr = 32'h4; ld_data = 32'hDEAD_BEEF;
        tick("ld");
        ld_addr = 32'h100; ld_data = 32'h1111_1111; ld_done = 1;
        tick("ld+done");
        ld_valid = 0; ld_done = 0;
        chk("run_after_done", {31'b0, core_run}, 32'd1);
        chk("ld_ready_run", {31'b0, ld_ready}, 32'd0);

        // Ten RUN edges, the first of which fetches 0x4
        imem_addr = 32'h4;
        tick("fetch");
        chk("fetch_0x4", imem_datain, 32'hDEAD_BEEF);
        repeat (9) tick("idle");
        load(IOB + 4);
        chk("cycle_10", dmem_datain, 32'd10);

        // Read-before-write on the same word, then new data
        memrw = 1; dmem_addr = 32'h100; dmem_dataout = 32'h1234_5678;
        tick("store+read");
        memrw = 0;
        chk("rbw_old", dmem_datain, 32'h1111_1111);
        load(32'h100);
        chk("rbw_new", dmem_datain, 32'h1234_5678);

        // 0x1000 aliases to word 0
        store(32'h1000, 32'hA5A5_A5A5);
        imem_addr = 32'h0;
        load(32'h0);
        chk("alias", dmem_datain, 32'hA5A5_A5A5);

        // Misaligned store sets the sticky flag and still lands on the word
        store(32'h102, 32'hCAFE_F00D);
        load(IOB + 8);
        chk("status_set", dmem_datain, 32'd1);
        load(32'h100);
        chk("misalign_word", dmem_datain, 32'hCAFE_F00D);
        store(IOB + 8, 32'h0000_0001);
        load(IOB + 8);
        chk("status_clr", dmem_datain, 32'd0);
        imem_addr = IOB + 4;
        load(IOB + 32'h10);
        chk("io_other", dmem_datain, 32'd0);
        chk("imem_io", imem_datain, 32'd0);

        // Halt, then stores are ignored and CYCLE stops
        store(IOB, 32'h0000_002A);
        chk("halted", {31'b0, halted}, 32'd1);
        chk("halt_run", {31'b0, core_run}, 32'd0);
        chk("halt_code", halt_code, 32'h0000_002A);
        store(32'h100, 32'h5555_5555);
        load(32'h100);
        chk("halt_nostore", dmem_datain, 32'hCAFE_F00D);
        load(IOB);
        chk("halt_reg_rd", dmem_datain, 32'h0000_002A);
        load(IOB + 4);
        repeat (3) tick("halt_idle");

        // Reset while halted keeps the array
        #2 rst = 0;
        @(negedge clk);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_run", {31'b0, core_run}, 32'd0);
        chk("rst_ready", {31'b0, ld_ready}, 32'd1);
        chk("rst_code", halt_code, 32'd0);
        #2 rst = 1;
        memrw = 1; dmem_addr = 32'h4; dmem_dataout = 32'h0;
        tick("store_in_load");
        memrw = 0;
        load(32'h4);
        chk("retain_0x4", dmem_datain, 32'hDEAD_BEEF);
        load(IOB + 4);
        chk("cycle_load", dmem_datain, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
